// File: rtl/ah_snoop_hazard_gate_pkg.sv
// Shared types for the snoopable write FIFO ordering gate.
package ah_snoop_pkg;

  localparam int unsigned DATA_W_DEFAULT = 140;

  typedef enum logic [1:0] {
    IDLE,
    SNOOP,
    WAIT,
    FWD
  } snoop_gate_state_t;

endpackage

// File: rtl/ah_snoop_hazard_gate_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ah_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ah_snoop_hazard_gate.sv
// Holds a request while it hits an in-flight FIFO entry; forwards it once a snoop misses.
module ah_snoop_hazard_gate
  import ah_snoop_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned RETRY_GAP = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sdata,
  output logic              svalid,
  input  logic              smatch,
  output logic              busy,
  output logic [CNT_W-1:0]  hazard_cnt
);

  localparam int unsigned      GAP_W    = $clog2(RETRY_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRY_GAP - 1);

  snoop_gate_state_t state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              accept;
  logic              hit;

  assign accept = req_valid && req_ready;
  assign hit    = (state_q == SNOOP) && smatch;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = req_data;
          state_d = SNOOP;
        end
      end
      SNOOP: begin
        if (smatch) begin
          gap_d   = GAP_LOAD;
          state_d = WAIT;
        end else begin
          state_d = FWD;
        end
      end
      // Counter runs RETRY_GAP-1 down to 0 inclusive: exactly RETRY_GAP idle cycles.
      WAIT: begin
        if (gap_q == '0) begin
          state_d = SNOOP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      FWD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !rstn;
    svalid    = (state_q == SNOOP);
    out_valid = (state_q == FWD);
    busy      = (state_q != IDLE);
  end

  assign sdata    = hold_q;
  assign out_data = hold_q;

  ah_sat_counter #(
    .WIDTH(CNT_W)
  ) u_hazard_cnt (
    .clk  (clk),
    .clr_i(rstn),
    .inc_i(hit),
    .cnt_o(hazard_cnt)
  );

endmodule
